alarm_scheduler: RTL
====================

ALARM_SCHEDULER -- requirements
Module: alarm_scheduler

Interface
REQ-001 SHALL have parameter EXIT_DELAY, default 16, arming grace period in clk cycles (>=1).
REQ-002 SHALL have parameter ENTRY_DELAY, default 16, disarm window after intrusion in clk cycles (>=1).
REQ-003 SHALL have parameter SIREN_TIME, default 64, maximum siren-on cycles before auto-silence (>=1).
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  system clock, rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 arm_req  in  1  single-cycle request to arm the house.
REQ-008 disarm_req  in  1  single-cycle unlock pulse from the password checker.
REQ-009 lockout_req  in  1  password-lockout alarm request.
REQ-010 fire_req  in  4  per-zone smoke-detector levels.
REQ-011 door_open / window_open  in  4 each  per-opening open levels.
REQ-012 garage_open  in  1  garage-open level.
REQ-013 ack  in  1  single-cycle silence/clear request.
REQ-014 siren  out  1  shared siren drive.
REQ-015 armed  out  1  high in ARMED and ENTRY_DLY.
REQ-016 alarm_cause  out  2  0 NONE, 1 BURGLAR, 2 LOCKOUT, 3 FIRE.
REQ-017 state_o  out  3  current FSM state encoding.
REQ-018 notify_valid / notify_code  out  1 / 2  alarm notification; notify_ready  in  1  consumer accept.

Function
REQ-019 FSM SHALL have states DISARMED, EXIT_DLY, ARMED, ENTRY_DLY, ALARM; all outputs registered.
REQ-020 intrusion SHALL be |door_open | |window_open | garage_open; fire SHALL be |fire_req.
REQ-021 DISARMED: arm_req -> EXIT_DLY; arm_req with disarm_req in the same cycle -> stay DISARMED.
REQ-022 EXIT_DLY SHALL last exactly EXIT_DELAY cycles then enter ARMED; disarm_req -> DISARMED; intrusion ignored.
REQ-023 ARMED: disarm_req -> DISARMED (wins over simultaneous intrusion); intrusion -> ENTRY_DLY.
REQ-024 ENTRY_DLY: disarm_req within ENTRY_DELAY cycles -> DISARMED; on expiry -> ALARM, cause BURGLAR.
REQ-025 fire in any state SHALL enter/stay ALARM with cause FIRE the next cycle, overriding disarm_req, arm_req and ack.
REQ-026 lockout_req in any state SHALL enter ALARM with cause LOCKOUT unless cause is already FIRE.
REQ-027 In ALARM a higher-priority cause (FIRE > LOCKOUT > BURGLAR) SHALL upgrade alarm_cause and restart the siren timer; lower never downgrades.
REQ-028 siren SHALL be 1 from ALARM entry for SIREN_TIME cycles, then 0 (ALARM held silent).
REQ-029 ack in ALARM SHALL go to DISARMED, cause NONE, siren 0 next cycle; ignored while fire is present.
REQ-030 Timers SHALL restart from full value on every state entry; no wrap-around.
REQ-031 Each ALARM entry or upgrade SHALL assert notify_valid with notify_code=cause; held until notify_valid & notify_ready; an upgrade while pending overwrites notify_code (only exception to stability).

Reset
REQ-032 rst SHALL force DISARMED, siren 0, armed 0, alarm_cause 0, notify_valid 0, notify_code 0, timers 0 immediately, including mid-alarm or mid-delay.

Configuration
REQ-033 With ALARM_NOTIFY_EN defined, notification handshake per REQ-031 is built.
REQ-034 Without ALARM_NOTIFY_EN, notify_valid and notify_code SHALL be tied 0, notify_ready ignored, no notify logic synthesized.

Structure
REQ-035 Package alarm_pkg SHALL hold the state enum, cause enum and default delay constants.
REQ-036 One sub-module delay_timer (loadable down-counter with done flag) SHALL be instantiated for exit/entry/siren timing.

Verification
REQ-037 arm_req, no sensors, EXIT_DELAY=16 -> state ARMED exactly 16 cycles later, armed=1.
REQ-038 ARMED, door_open=4'b0001, disarm_req at cycle 10 of 16 -> DISARMED, siren never 1.
REQ-039 ARMED, window_open=4'b0100, no disarm -> ALARM after 16 cycles, cause 1, siren 1 for 64 cycles then 0.
REQ-040 DISARMED, fire_req=4'b1000 with ack and disarm_req pulsed -> cause 3, siren 1, ack ignored; fire_req=0 then ack -> DISARMED.
REQ-041 BURGLAR alarm, notify_ready=0, lockout_req pulse -> notify_code 1->2 with notify_valid held; notify_ready=1 -> notify_valid 0 next cycle.
REQ-042 rst asserted mid-ENTRY_DLY and mid-ALARM -> all outputs 0 asynchronously, DISARMED after release.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and default timing constants for the alarm scheduler.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED  = 3'd0,
    ST_EXIT_DLY  = 3'd1,
    ST_ARMED     = 3'd2,
    ST_ENTRY_DLY = 3'd3,
    ST_ALARM     = 3'd4
  } state_e;

  // Numeric order doubles as priority: a larger code always wins.
  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_BURGLAR = 2'd1,
    CAUSE_LOCKOUT = 2'd2,
    CAUSE_FIRE    = 2'd3
  } cause_e;

  localparam int DEF_EXIT_DELAY  = 16;
  localparam int DEF_ENTRY_DELAY = 16;
  localparam int DEF_SIREN_TIME  = 64;

  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/delay_timer.sv
// Loadable saturating down-counter; done_o flags the last counted cycle.
module delay_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] count_o,
  output logic         done_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign done_o  = (count_q == W'(1));

endmodule

// File: rtl/alarm_scheduler.sv
// House alarm FSM with exit/entry delays, prioritised alarm causes and siren timeout.
// Optional notification handshake is built only when ALARM_NOTIFY_EN is defined.
module alarm_scheduler
  import alarm_pkg::*;
#(
  parameter int EXIT_DELAY  = DEF_EXIT_DELAY,
  parameter int ENTRY_DELAY = DEF_ENTRY_DELAY,
  parameter int SIREN_TIME  = DEF_SIREN_TIME
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arm_req,
  input  logic       disarm_req,
  input  logic       lockout_req,
  input  logic [3:0] fire_req,
  input  logic [3:0] door_open,
  input  logic [3:0] window_open,
  input  logic       garage_open,
  input  logic       ack,
  output logic       siren,
  output logic       armed,
  output logic [1:0] alarm_cause,
  output logic [2:0] state_o,
  output logic       notify_valid,
  output logic [1:0] notify_code,
  input  logic       notify_ready
);

  localparam int TW = timer_width(EXIT_DELAY, ENTRY_DELAY, SIREN_TIME);

  state_e         state_q, state_d;
  cause_e         cause_q, cause_d;
  logic           siren_q, siren_d;
  logic           armed_q, armed_d;
  logic           intrusion, fire;
  logic           tmr_load, tmr_done;
  logic [TW-1:0]  tmr_val, tmr_count;

  assign intrusion = (|door_open) | (|window_open) | garage_open;
  assign fire      = |fire_req;

  // Fire beats everything, lockout beats everything but an existing fire alarm.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    if (fire) begin
      state_d = ST_ALARM;
      cause_d = CAUSE_FIRE;
    end else if (lockout_req && (cause_q != CAUSE_FIRE)) begin
      state_d = ST_ALARM;
      cause_d = CAUSE_LOCKOUT;
    end else begin
      case (state_q)
        ST_DISARMED:  if (arm_req && !disarm_req) state_d = ST_EXIT_DLY;
        ST_EXIT_DLY: begin
          if (disarm_req)    state_d = ST_DISARMED;
          else if (tmr_done) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (disarm_req)     state_d = ST_DISARMED;
          else if (intrusion) state_d = ST_ENTRY_DLY;
        end
        ST_ENTRY_DLY: begin
          if (disarm_req) begin
            state_d = ST_DISARMED;
          end else if (tmr_done) begin
            state_d = ST_ALARM;
            cause_d = CAUSE_BURGLAR;
          end
        end
        ST_ALARM:     if (ack) state_d = ST_DISARMED;
        default:      state_d = ST_DISARMED;
      endcase
    end
    if (state_d != ST_ALARM) cause_d = CAUSE_NONE;
  end

  // One timer serves every timed state; an upgrade restarts the siren window.
  assign tmr_load = (state_d != state_q) || (cause_d > cause_q);

  always_comb begin
    tmr_val = '0;
    case (state_d)
      ST_EXIT_DLY:  tmr_val = TW'(EXIT_DELAY);
      ST_ENTRY_DLY: tmr_val = TW'(ENTRY_DELAY);
      ST_ALARM:     tmr_val = TW'(SIREN_TIME);
      default:      tmr_val = '0;
    endcase
  end

  delay_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .count_o    (tmr_count),
    .done_o     (tmr_done)
  );

  assign siren_d = (state_d == ST_ALARM) && (tmr_load || (tmr_count > TW'(1)));
  assign armed_d = (state_d == ST_ARMED) || (state_d == ST_ENTRY_DLY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_DISARMED;
      cause_q <= CAUSE_NONE;
      siren_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      siren_q <= siren_d;
      armed_q <= armed_d;
    end
  end

  assign siren       = siren_q;
  assign armed       = armed_q;
  assign alarm_cause = cause_q;
  assign state_o     = state_q;

`ifdef ALARM_NOTIFY_EN
  logic   nvalid_q, nvalid_d;
  cause_e ncode_q, ncode_d;
  logic   notify_event;

  assign notify_event = (state_d == ST_ALARM) &&
                        ((state_q != ST_ALARM) || (cause_d != cause_q));

  // A fresh event overrides a completing handshake so it is never lost.
  always_comb begin
    nvalid_d = nvalid_q;
    ncode_d  = ncode_q;
    if (notify_event) begin
      nvalid_d = 1'b1;
      ncode_d  = cause_d;
    end else if (nvalid_q && notify_ready) begin
      nvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nvalid_q <= 1'b0;
      ncode_q  <= CAUSE_NONE;
    end else begin
      nvalid_q <= nvalid_d;
      ncode_q  <= ncode_d;
    end
  end

  assign notify_valid = nvalid_q;
  assign notify_code  = ncode_q;
`else
  logic unused_notify_ready;
  assign unused_notify_ready = notify_ready;
  assign notify_valid        = 1'b0;
  assign notify_code         = 2'b00;
`endif

endmodule
